// File: rtl/pe_launch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_launch_ctrl_pkg
// Description : Shared definitions for the PE launch controller. Holds the
//               run-state encoding, register indices, CTRL/IRQ_CLR bit
//               positions, STATUS field positions, and a small state helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_launch_ctrl_pkg;

    // Run-state encoding. The value is visible to the host in STATUS[2:0].
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PULSE = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // Register indices on the chip-select bus
    localparam logic [2:0] C_REG_CTRL       = 3'd0;
    localparam logic [2:0] C_REG_STATUS     = 3'd1;
    localparam logic [2:0] C_REG_EXPECT     = 3'd2;
    localparam logic [2:0] C_REG_TIMEOUT    = 3'd3;
    localparam logic [2:0] C_REG_RESULT_CNT = 3'd4;
    localparam logic [2:0] C_REG_IRQ_CLR    = 3'd5;

    // CTRL and IRQ_CLR bit positions
    localparam int C_CTRL_START_BIT = 0;
    localparam int C_CTRL_ABORT_BIT = 1;
    localparam int C_CTRL_IRQEN_BIT = 2;
    localparam int C_IRQCLR_BIT     = 0;

    // STATUS field positions
    localparam int C_STAT_STATE_LSB = 0;
    localparam int C_STAT_STATE_W   = 3;
    localparam int C_STAT_DONE_BIT  = 3;
    localparam int C_STAT_TMO_BIT   = 4;

    // A launch is in flight (shader held in reset pulse or running)
    function automatic logic is_active(input state_e s);
        return (s == ST_PULSE) || (s == ST_RUN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : pe_watchdog
// Description : Loadable down-counter used as the launch watchdog. Loading a
//               zero value leaves it disarmed, so it never expires.
// Ports       : clk_i       - clock
//               rst_ni      - async active-low reset
//               load_i      - load load_val_i (arms when non-zero)
//               load_val_i  - reload value
//               dec_i       - decrement enable (one count per cycle)
//               expire_o    - this cycle's decrement reaches zero
//               zero_o      - counter currently holds zero
// Revision    : 1.0 - initial release
// ============================================================================
module pe_watchdog #(
    parameter int Width = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expire_o,
    output logic             zero_o
);

    logic [Width-1:0] count_q, count_d;
    logic             armed_q, armed_d;

    always_comb begin
        count_d = count_q;
        armed_d = armed_q;
        if (load_i) begin
            count_d = load_val_i;
            armed_d = (load_val_i != '0);
        end else if (dec_i && armed_q) begin
            count_d = count_q - 1'b1;
            // Disarm on the final count so it fires exactly once per load
            if (count_q == Width'(1)) begin
                armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            armed_q <= 1'b0;
        end else begin
            count_q <= count_d;
            armed_q <= armed_d;
        end
    end

    // Expiry is flagged in the cycle whose decrement takes the count to zero,
    // so a load of N fires at the end of the Nth enabled cycle.
    assign expire_o = dec_i && armed_q && (count_q == Width'(1));
    assign zero_o   = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/pe_launch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pe_launch_ctrl
// Description : Host-facing run controller for one PE shader instance. Owns
//               the shader reset, sequences launch (reset pulse, run, result
//               counting, completion or watchdog timeout), and exposes
//               control/status registers and a level interrupt.
// Ports       : iClk, iReset_n          - clock, async active-low reset
//               iChipSelect_n, iWrite_n,
//               iRead_n, iAddress, iData - register bus (active-low strobes)
//               oData                    - registered read data (1 cycle)
//               iReady_out               - PE lane ready; all high = 1 beat
//               oShader_rst_n            - shader reset, high only in RUN
//               oLoad_allow              - instruction ROM writes permitted
//               oBusy                    - launch in flight (PULSE or RUN)
//               oIrq                     - irq_en & (done | timeout)
// Revision    : 1.0 - initial release
// ============================================================================
module pe_launch_ctrl
    import pe_launch_ctrl_pkg::*;
#(
    parameter int CntWidth       = 16,
    parameter int TimeoutWidth   = 24,
    parameter int RstPulseCycles = 2
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iChipSelect_n,
    input  logic        iWrite_n,
    input  logic        iRead_n,
    input  logic [2:0]  iAddress,
    input  logic [31:0] iData,
    output logic [31:0] oData,
    input  logic [3:0]  iReady_out,
    output logic        oShader_rst_n,
    output logic        oLoad_allow,
    output logic        oBusy,
    output logic        oIrq
);

    localparam int PulseW = $clog2(RstPulseCycles + 1);

    state_e                  state_q, state_d;
    logic [PulseW-1:0]       pulse_cnt_q, pulse_cnt_d;
    logic [CntWidth-1:0]     expect_q, expect_d;
    logic [TimeoutWidth-1:0] timeout_q, timeout_d;
    logic [CntWidth-1:0]     result_cnt_q, result_cnt_d;
    logic                    done_q, done_d;
    logic                    tmo_q, tmo_d;
    logic                    irq_en_q, irq_en_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    shader_rst_n_q, shader_rst_n_d;
    logic                    load_allow_q, load_allow_d;
    logic                    busy_q, busy_d;
    logic                    irq_q, irq_d;

    logic                    w_wr, w_rd, w_ctrl_wr;
    logic                    w_start, w_abort, w_irq_clr;
    logic                    w_beat, w_complete;
    logic [CntWidth:0]       w_cnt_inc;
    logic                    w_wd_load, w_wd_dec, w_wd_expire, w_wd_zero;
    logic                    w_unused_bits;

    assign w_wr      = !iChipSelect_n && !iWrite_n;
    assign w_rd      = !iChipSelect_n && !iRead_n;
    assign w_ctrl_wr = w_wr && (iAddress == C_REG_CTRL);
    assign w_abort   = w_ctrl_wr && iData[C_CTRL_ABORT_BIT];
    // Abort in the same write suppresses start
    assign w_start   = w_ctrl_wr && iData[C_CTRL_START_BIT] && !iData[C_CTRL_ABORT_BIT];
    assign w_irq_clr = w_wr && (iAddress == C_REG_IRQ_CLR) && iData[C_IRQCLR_BIT];

    assign w_beat     = (state_q == ST_RUN) && (&iReady_out);
    // One bit wider so a saturated counter never aliases onto EXPECT
    assign w_cnt_inc  = (CntWidth+1)'(result_cnt_q) + (CntWidth+1)'(1);
    assign w_complete = w_beat && (w_cnt_inc == (CntWidth+1)'(expect_q));

    // Watchdog is armed on the last PULSE cycle and counts only in RUN
    assign w_wd_load = (state_q == ST_PULSE) && (pulse_cnt_q == PulseW'(1)) && !w_abort;
    assign w_wd_dec  = (state_q == ST_RUN);

    pe_watchdog #(
        .Width (TimeoutWidth)
    ) u_watchdog (
        .clk_i      (iClk),
        .rst_ni     (iReset_n),
        .load_i     (w_wd_load),
        .load_val_i (timeout_q),
        .dec_i      (w_wd_dec),
        .expire_o   (w_wd_expire),
        .zero_o     (w_wd_zero)
    );

    // High data bits beyond the widest register and the zero flag are unused
    assign w_unused_bits = ^{iData, w_wd_zero};

    always_comb begin
        state_d      = state_q;
        pulse_cnt_d  = pulse_cnt_q;
        expect_d     = expect_q;
        timeout_d    = timeout_q;
        result_cnt_d = result_cnt_q;
        irq_en_d     = irq_en_q;
        rdata_d      = rdata_q;
        // IRQ_CLR drops the old flags; a flag set below still wins
        done_d       = done_q && !w_irq_clr;
        tmo_d        = tmo_q && !w_irq_clr;

        // Register writes (launch parameters are frozen while in flight)
        if (w_wr) begin
            case (iAddress)
                C_REG_CTRL:    irq_en_d = iData[C_CTRL_IRQEN_BIT];
                C_REG_EXPECT:  if (!is_active(state_q)) expect_d = iData[CntWidth-1:0];
                C_REG_TIMEOUT: if (!is_active(state_q)) timeout_d = iData[TimeoutWidth-1:0];
                default:       ;
            endcase
        end

        // Launch sequencer
        if (w_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (w_start) begin
                        tmo_d = 1'b0;
                        if (expect_q != '0) begin
                            state_d      = ST_PULSE;
                            pulse_cnt_d  = PulseW'(RstPulseCycles);
                            result_cnt_d = '0;
                            done_d       = 1'b0;
                        end else begin
                            // Nothing to wait for: complete without releasing the shader
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_PULSE: begin
                    pulse_cnt_d = pulse_cnt_q - 1'b1;
                    if (pulse_cnt_q == PulseW'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_beat && (result_cnt_q != '1)) begin
                        result_cnt_d = result_cnt_q + 1'b1;
                    end
                    // Completion outranks a simultaneous watchdog expiry
                    if (w_complete) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (w_wd_expire) begin
                        state_d = ST_ERR;
                        tmo_d   = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Read path samples the pre-edge register values
        if (w_rd) begin
            rdata_d = '0;
            case (iAddress)
                C_REG_STATUS: begin
                    rdata_d[C_STAT_STATE_LSB +: C_STAT_STATE_W] = state_q;
                    rdata_d[C_STAT_DONE_BIT] = done_q;
                    rdata_d[C_STAT_TMO_BIT]  = tmo_q;
                end
                C_REG_EXPECT:     rdata_d = 32'(expect_q);
                C_REG_TIMEOUT:    rdata_d = 32'(timeout_q);
                C_REG_RESULT_CNT: rdata_d = 32'(result_cnt_q);
                default:          rdata_d = '0;
            endcase
        end

        // Outputs are derived from the next state so they register in step
        shader_rst_n_d = (state_d == ST_RUN);
        busy_d         = is_active(state_d);
        load_allow_d   = !is_active(state_d);
        irq_d          = irq_en_d && (done_d || tmo_d);
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q        <= ST_IDLE;
            pulse_cnt_q    <= '0;
            expect_q       <= '0;
            timeout_q      <= '0;
            result_cnt_q   <= '0;
            done_q         <= 1'b0;
            tmo_q          <= 1'b0;
            irq_en_q       <= 1'b0;
            rdata_q        <= '0;
            shader_rst_n_q <= 1'b0;
            load_allow_q   <= 1'b1;
            busy_q         <= 1'b0;
            irq_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            pulse_cnt_q    <= pulse_cnt_d;
            expect_q       <= expect_d;
            timeout_q      <= timeout_d;
            result_cnt_q   <= result_cnt_d;
            done_q         <= done_d;
            tmo_q          <= tmo_d;
            irq_en_q       <= irq_en_d;
            rdata_q        <= rdata_d;
            shader_rst_n_q <= shader_rst_n_d;
            load_allow_q   <= load_allow_d;
            busy_q         <= busy_d;
            irq_q          <= irq_d;
        end
    end

    assign oData         = rdata_q;
    assign oShader_rst_n = shader_rst_n_q;
    assign oLoad_allow   = load_allow_q;
    assign oBusy         = busy_q;
    assign oIrq          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_launch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_launch_ctrl
// Description : Self-checking bench for pe_launch_ctrl. Register reads push
//               their expected value into a scoreboard queue; a monitor pops
//               and compares when read data appears. Pin-level checks are
//               made directly at the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_launch_ctrl;

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_STATUS  = 3'd1;
    localparam logic [2:0] A_EXPECT  = 3'd2;
    localparam logic [2:0] A_TIMEOUT = 3'd3;
    localparam logic [2:0] A_RESCNT  = 3'd4;
    localparam logic [2:0] A_IRQCLR  = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n, wr_n, rd_n;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  ready;
    logic        shader_rst_n, load_allow, busy, irq;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    logic rd_pend;

    always #5 clk = ~clk;

    pe_launch_ctrl dut (
        .iClk          (clk),
        .iReset_n      (rst_n),
        .iChipSelect_n (cs_n),
        .iWrite_n      (wr_n),
        .iRead_n       (rd_n),
        .iAddress      (addr),
        .iData         (wdata),
        .oData         (rdata),
        .iReady_out    (ready),
        .oShader_rst_n (shader_rst_n),
        .oLoad_allow   (load_allow),
        .oBusy         (busy),
        .oIrq          (irq)
    );

    // Monitor: a read sampled at a rising edge returns data by the next falling edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_pend <= 1'b0;
        else        rd_pend <= !cs_n && !rd_n;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rd_pend) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: got %h, no expectation queued", rdata);
            end else begin
                e = sb.pop_front();
                if (rdata !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h, want %h", e.name, rdata, e.val);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cs_n = 1'b0; wr_n = 1'b0; addr = a; wdata = d;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        cs_n = 1'b0; rd_n = 1'b0; addr = a;
        sb.push_back('{name: nm, val: e});
        @(negedge clk);
        cs_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        addr = '0; wdata = '0; ready = '0;
        tick(2);

        // Reset values
        chk("rst_shader_rst_n", 32'(shader_rst_n), 0);
        chk("rst_load_allow", 32'(load_allow), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_odata", rdata, 0);
        rst_n = 1'b1;
        tick(1);
        rd(A_STATUS, 32'h0, "rst_status");
        rd(A_EXPECT, 32'h0, "rst_expect");

        // Normal launch: EXPECT=3, TIMEOUT=100, irq_en
        wr(A_EXPECT, 3);
        wr(A_TIMEOUT, 100);
        wr(A_CTRL, 32'h5);
        chk("pulse1_shader_rst_n", 32'(shader_rst_n), 0);
        chk("pulse1_busy", 32'(busy), 1);
        chk("pulse1_load_allow", 32'(load_allow), 0);
        tick(1);
        chk("pulse2_shader_rst_n", 32'(shader_rst_n), 0);
        tick(1);
        chk("run_shader_rst_n", 32'(shader_rst_n), 1);
        ready = 4'hF;
        tick(2);
        chk("run_after_2_beats", 32'(shader_rst_n), 1);
        tick(1);
        ready = 4'h0;
        chk("done_shader_rst_n", 32'(shader_rst_n), 0);
        chk("done_irq", 32'(irq), 1);
        chk("done_load_allow", 32'(load_allow), 1);
        rd(A_RESCNT, 32'd3, "normal_result_cnt");
        rd(A_STATUS, 32'h0B, "normal_status");
        rd(A_TIMEOUT, 32'd100, "normal_timeout_rb");

        // Partial ready never counts as a beat
        wr(A_CTRL, 32'h5);
        tick(2);
        chk("relaunch_irq_cleared", 32'(irq), 0);
        ready = 4'b0111;
        tick(10);
        rd(A_RESCNT, 32'd0, "partial_result_cnt");
        rd(A_STATUS, 32'h02, "partial_status_run");
        ready = 4'h0;
        wr(A_CTRL, 32'h6);
        chk("abort_busy", 32'(busy), 0);
        rd(A_STATUS, 32'h00, "abort_status");

        // Timeout: 8 RUN cycles without beats
        wr(A_EXPECT, 5);
        wr(A_TIMEOUT, 8);
        wr(A_CTRL, 32'h5);
        tick(9);
        chk("tmo_run_cycle8", 32'(shader_rst_n), 1);
        tick(1);
        chk("tmo_err_shader_rst_n", 32'(shader_rst_n), 0);
        chk("tmo_irq", 32'(irq), 1);
        rd(A_STATUS, 32'h14, "tmo_status");
        wr(A_IRQCLR, 1);
        chk("irqclr_irq", 32'(irq), 0);
        rd(A_STATUS, 32'h04, "irqclr_status");

        // Collision: third beat on the watchdog's final count
        wr(A_EXPECT, 3);
        wr(A_TIMEOUT, 3);
        wr(A_CTRL, 32'h5);
        tick(2);
        ready = 4'hF;
        tick(3);
        ready = 4'h0;
        chk("coll_shader_rst_n", 32'(shader_rst_n), 0);
        rd(A_STATUS, 32'h0B, "coll_status_done");
        rd(A_RESCNT, 32'd3, "coll_result_cnt");

        // Start and EXPECT write during RUN are ignored; watchdog disabled
        wr(A_TIMEOUT, 0);
        wr(A_CTRL, 32'h5);
        tick(2);
        ready = 4'hF;
        tick(1);
        ready = 4'h0;
        wr(A_CTRL, 32'h5);
        wr(A_EXPECT, 7);
        rd(A_RESCNT, 32'd1, "start_in_run_cnt");
        rd(A_STATUS, 32'h02, "start_in_run_status");
        cs_n = 1'b0; rd_n = 1'b0; addr = A_EXPECT;
        sb.push_back('{name: "expect_locked", val: 32'd3});
        #1;
        chk("read_latency_hold", rdata, 32'h02);
        @(negedge clk);
        cs_n = 1'b1; rd_n = 1'b1;
        tick(20);
        rd(A_STATUS, 32'h02, "wd_disabled_run");

        // Abort and start in one write
        wr(A_CTRL, 32'h7);
        chk("abort_start_run_busy", 32'(busy), 0);
        chk("abort_start_run_shader", 32'(shader_rst_n), 0);
        rd(A_STATUS, 32'h00, "abort_start_run_status");
        wr(A_CTRL, 32'h7);
        chk("abort_start_idle_busy", 32'(busy), 0);
        rd(A_STATUS, 32'h00, "abort_start_idle_status");

        // Zero expect: straight to DONE, shader stays in reset
        wr(A_EXPECT, 0);
        wr(A_CTRL, 32'h5);
        chk("zexp_shader_rst_n", 32'(shader_rst_n), 0);
        chk("zexp_busy", 32'(busy), 0);
        chk("zexp_irq", 32'(irq), 1);
        rd(A_STATUS, 32'h0B, "zexp_status");
        chk("zexp_shader_held", 32'(shader_rst_n), 0);

        // Asynchronous reset mid-RUN
        wr(A_EXPECT, 3);
        wr(A_CTRL, 32'h5);
        tick(2);
        ready = 4'hF;
        tick(1);
        ready = 4'h0;
        rd(A_RESCNT, 32'd1, "pre_reset_cnt");
        #2 rst_n = 1'b0;
        #1;
        chk("areset_shader_rst_n", 32'(shader_rst_n), 0);
        chk("areset_busy", 32'(busy), 0);
        chk("areset_irq", 32'(irq), 0);
        chk("areset_odata", rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        rd(A_STATUS, 32'h00, "post_reset_status");
        rd(A_RESCNT, 32'd0, "post_reset_cnt");
        rd(A_EXPECT, 32'd0, "post_reset_expect");

        tick(2);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_launch_ctrl.md
Name: pe_launch_ctrl

Overview:
Host-facing run controller for one PE shader instance and its instruction ROM / output buffer pair. It owns the shader reset line, sequences each launch (reset pulse, run, result counting, completion or timeout), and exposes control/status registers plus a level interrupt on the same chip-select bus used for program load and result readback. It sits beside the PE wrapper and replaces direct host control of the shader reset.

Parameters:
CntWidth, 16, width of expected-result counter and result counter
TimeoutWidth, 24, width of watchdog counter
RstPulseCycles, 2, cycles the shader reset is held low at launch (min 1)

Ports:
iClk  in  1  clock
iReset_n  in  1  async active-low reset
iChipSelect_n  in  1  register access select, active low
iWrite_n  in  1  write strobe, active low
iRead_n  in  1  read strobe, active low
iAddress  in  3  register index
iData  in  32  write data
oData  out  32  read data, registered
iReady_out  in  4  PE lane ready flags; a result beat is a cycle with all four high
oShader_rst_n  out  1  PE shader reset, active low
oLoad_allow  out  1  1 when instruction ROM writes are permitted
oBusy  out  1  1 in PULSE or RUN
oIrq  out  1  level interrupt

Behaviour:
- Reset is asynchronous and active-low on iReset_n; clock is iClk. Reset values: state IDLE, oShader_rst_n=0, oLoad_allow=1, oBusy=0, oIrq=0, oData=0, all registers 0.
- Registers: 0 CTRL W (bit0 start, bit1 abort, bit2 irq_en; start/abort self-clear), 1 STATUS R ({27'b0, timeout, done, state[2:0]}), 2 EXPECT RW (CntWidth), 3 TIMEOUT RW (TimeoutWidth; 0 disables watchdog), 4 RESULT_CNT R, 5 IRQ_CLR W (bit0 clears done/timeout flags and oIrq). Unmapped writes are ignored; unmapped reads return 0.
- Writes take effect on the clock edge where iChipSelect_n=0 and iWrite_n=0. Reads: oData is updated at the edge after iChipSelect_n=0 and iRead_n=0, so read latency is 1 cycle. oData holds its value otherwise.
- State encoding: IDLE=0, PULSE=1, RUN=2, DONE=3, ERR=4.
- IDLE: oShader_rst_n=0, oLoad_allow=1. Start with EXPECT!=0 loads the pulse counter with RstPulseCycles, clears RESULT_CNT and the done/timeout flags, then goes to PULSE. Start with EXPECT=0 goes straight to DONE with done=1.
- PULSE: oShader_rst_n=0, oLoad_allow=0. After RstPulseCycles cycles, load the watchdog with TIMEOUT and go to RUN.
- RUN: oShader_rst_n=1. Each result beat increments RESULT_CNT (saturating). On the beat where RESULT_CNT+1==EXPECT, go to DONE with done=1. If TIMEOUT!=0, the watchdog decrements each RUN cycle; reaching 0 without completion goes to ERR with timeout=1. If completion and watchdog expiry occur in the same cycle, completion wins.
- DONE/ERR: oShader_rst_n=0, which freezes the PE and preserves its output buffer. oLoad_allow=1. Start relaunches exactly as from IDLE.
- Abort in any state goes to IDLE with oShader_rst_n=0 and flags unchanged. Abort takes priority over start in the same write.
- Start issued in PULSE or RUN is ignored.
- Writes to EXPECT and TIMEOUT during PULSE or RUN are ignored.
- oIrq = irq_en & (done | timeout). IRQ_CLR has priority over a flag set in the same cycle only for the old flag; a newly set flag still asserts.
- Beats seen outside RUN are not counted.

Decomposition:
- Shared package/header holds the state encodings, register index constants, and STATUS bit positions.
- One natural sub-module: pe_watchdog (loadable down-counter with enable, zero flag, and disable-on-zero-load).

Test Plan:
- Reset: assert iReset_n=0 mid-RUN -> immediately oShader_rst_n=0, state 0, oIrq=0, RESULT_CNT=0.
- Normal launch: EXPECT=3, TIMEOUT=100, irq_en=1, start; drive 3 beats in RUN -> oShader_rst_n low for exactly 2 cycles then high; DONE the cycle after the 3rd beat; RESULT_CNT=3; oIrq=1; STATUS=0x0B.
- Partial ready: iReady_out=4'b0111 for 10 cycles -> RESULT_CNT stays 0, remains RUN.
- Timeout: EXPECT=5, TIMEOUT=8, no beats -> ERR after 8 RUN cycles; STATUS=0x14; IRQ_CLR=1 -> oIrq=0.
- Collision/priority: 3rd beat coincident with watchdog zero -> DONE, timeout=0. Start in RUN -> no effect. Abort+start same write -> IDLE.
- Zero expect and register lock: EXPECT=0 start -> DONE next cycle, shader never released. Write EXPECT during RUN -> read back still old value, with 1-cycle read latency checked.
